// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit between the AGU and a DTCM port.
//   clk, rst          : single clock, synchronous active-high reset
//   agu_cmd_*         : incoming load/store command (valid/ready handshake)
//   dtcm_cmd_*        : word-aligned DTCM request with byte mask and lane-replicated store data
//   dtcm_rsp_*        : in-order DTCM response (valid/ready handshake)
//   lsu_o_*           : registered writeback (data, tag, misalignment error)
// Every accepted command gets an entry in an in-order outstanding FIFO so writebacks
// leave in acceptance order; misaligned commands skip the DTCM and retire as errors.
module lsu_pipe #(
  parameter int OUTS_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int ITAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agu_cmd_valid,
  output logic              agu_cmd_ready,
  input  logic              agu_cmd_read,
  input  logic [ADDR_W-1:0] agu_cmd_addr,
  input  logic [31:0]       agu_cmd_wdata,
  input  logic [1:0]        agu_cmd_size,
  input  logic              agu_cmd_usign,
  input  logic [ITAG_W-1:0] agu_cmd_itag,
  output logic              dtcm_cmd_valid,
  input  logic              dtcm_cmd_ready,
  output logic              dtcm_cmd_read,
  output logic [ADDR_W-1:0] dtcm_cmd_addr,
  output logic [31:0]       dtcm_cmd_wdata,
  output logic [3:0]        dtcm_cmd_wmask,
  input  logic              dtcm_rsp_valid,
  output logic              dtcm_rsp_ready,
  input  logic [31:0]       dtcm_rsp_rdata,
  output logic              lsu_o_valid,
  input  logic              lsu_o_ready,
  output logic [31:0]       lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0] lsu_o_wbck_itag,
  output logic              lsu_o_wbck_err
);

  localparam int PW = $clog2(OUTS_DEPTH);
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  typedef struct packed {
    logic              read;
    logic [ITAG_W-1:0] itag;
    logic [1:0]        ofs;
    logic [1:0]        size;
    logic              usign;
    logic              err;
  } entry_t;

  entry_t        fifo [OUTS_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic   full, head_valid, misaligned, push, out_free, complete;
  entry_t head;
  logic [31:0] shifted, ext_data, wb_data;

  assign full       = (count == CW'(OUTS_DEPTH));
  assign head_valid = (count != '0);
  assign head       = fifo[rd_ptr];

  always_comb begin
    misaligned = 1'b0;
    case (agu_cmd_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = agu_cmd_addr[0];
      2'b10:   misaligned = (agu_cmd_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Misaligned commands are accepted without waiting on the DTCM since they never go there.
  assign agu_cmd_ready  = !full && (misaligned || dtcm_cmd_ready);
  assign dtcm_cmd_valid = agu_cmd_valid && !full && !misaligned;
  assign dtcm_cmd_read  = agu_cmd_read;
  assign dtcm_cmd_addr  = {agu_cmd_addr[ADDR_W-1:2], 2'b00};
  assign push           = agu_cmd_valid && agu_cmd_ready;

  always_comb begin
    dtcm_cmd_wmask = 4'b0000;
    dtcm_cmd_wdata = agu_cmd_wdata;
    case (agu_cmd_size)
      2'b00: begin
        dtcm_cmd_wdata = {4{agu_cmd_wdata[7:0]}};
        if (!agu_cmd_read) dtcm_cmd_wmask = 4'b0001 << agu_cmd_addr[1:0];
      end
      2'b01: begin
        dtcm_cmd_wdata = {2{agu_cmd_wdata[15:0]}};
        if (!agu_cmd_read) dtcm_cmd_wmask = 4'b0011 << {agu_cmd_addr[1], 1'b0};
      end
      default: begin
        if (!agu_cmd_read) dtcm_cmd_wmask = 4'b1111;
      end
    endcase
  end

  // Error entries retire without a DTCM response; others wait for one.
  assign out_free       = !lsu_o_valid || lsu_o_ready;
  assign complete       = head_valid && out_free && (head.err || dtcm_rsp_valid);
  assign dtcm_rsp_ready = head_valid && !head.err && out_free;

  assign shifted = dtcm_rsp_rdata >> {head.ofs, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (head.size)
      2'b00:   ext_data = {{24{!head.usign && shifted[7]}}, shifted[7:0]};
      2'b01:   ext_data = {{16{!head.usign && shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  assign wb_data = (head.read && !head.err) ? ext_data : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{read: agu_cmd_read, itag: agu_cmd_itag, ofs: agu_cmd_addr[1:0],
                        size: agu_cmd_size, usign: agu_cmd_usign, err: misaligned};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      lsu_o_valid     <= 1'b0;
      lsu_o_wbck_wdat <= '0;
      lsu_o_wbck_itag <= '0;
      lsu_o_wbck_err  <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (complete) rd_ptr <= rd_ptr + PW'(1);
      case ({push, complete})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (complete) begin
        lsu_o_valid     <= 1'b1;
        lsu_o_wbck_wdat <= wb_data;
        lsu_o_wbck_itag <= head.itag;
        lsu_o_wbck_err  <= head.err;
      end else if (lsu_o_ready) begin
        lsu_o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int TW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [AW-1:0] agu_cmd_addr;
  logic [31:0]   agu_cmd_wdata;
  logic [1:0]    agu_cmd_size;
  logic [TW-1:0] agu_cmd_itag;
  logic          dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [AW-1:0] dtcm_cmd_addr;
  logic [31:0]   dtcm_cmd_wdata;
  logic [3:0]    dtcm_cmd_wmask;
  logic          dtcm_rsp_valid, dtcm_rsp_ready;
  logic [31:0]   dtcm_rsp_rdata;
  logic          lsu_o_valid, lsu_o_ready, lsu_o_wbck_err;
  logic [31:0]   lsu_o_wbck_wdat;
  logic [TW-1:0] lsu_o_wbck_itag;

  lsu_pipe #(.OUTS_DEPTH(DEPTH), .ADDR_W(AW), .ITAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_usign(agu_cmd_usign), .agu_cmd_itag(agu_cmd_itag),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_wdat(lsu_o_wbck_wdat),
    .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_wbck_err(lsu_o_wbck_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic rd, input logic [15:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic us, input logic [3:0] tag);
    agu_cmd_valid = v;  agu_cmd_read = rd;  agu_cmd_addr = a;  agu_cmd_wdata = wd;
    agu_cmd_size  = sz; agu_cmd_usign = us; agu_cmd_itag = tag;
  endtask

  // Directed single-transaction vectors: inputs, then expected DTCM command and writeback.
  typedef struct {
    logic rd; logic [15:0] addr; logic [31:0] wd; logic [1:0] size; logic us; logic [3:0] tag;
    logic [31:0] rdata;
    logic xv; logic [15:0] xaddr; logic [3:0] xmask; logic [31:0] xwd; logic [31:0] xwb; logic xerr;
  } vec_t;
  vec_t vecs [12];

  typedef struct packed { logic [3:0] tag; logic [31:0] wd; logic err; } wb_t;
  wb_t         wb_q [$];
  logic [31:0] rsp_q [$];

  logic [31:0] dmem   [64];
  logic [7:0]  shadow [256];

  // Retires writebacks against wb_q while serving DTCM responses from rsp_q in order.
  task automatic collect(input int n);
    int wi = 0;
    for (int cyc = 0; cyc < 60 && wi < n; cyc++) begin
      dtcm_rsp_valid = (rsp_q.size() > 0);
      dtcm_rsp_rdata = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
      @(negedge clk);
      if (dtcm_rsp_valid && dtcm_rsp_ready) void'(rsp_q.pop_front());
      if (lsu_o_valid && lsu_o_ready) begin
        wb_t e;
        if (wb_q.size() == 0) begin
          chk("collect_extra_wb", 32'(wi), 32'(n));
        end else begin
          e = wb_q.pop_front();
          chk($sformatf("seq wb%0d tag", wi), 32'(lsu_o_wbck_itag), 32'(e.tag));
          chk($sformatf("seq wb%0d wdat", wi), lsu_o_wbck_wdat, e.wd);
          chk1($sformatf("seq wb%0d err", wi), lsu_o_wbck_err, e.err);
        end
        wi++;
      end
      @(posedge clk); #1;
    end
    dtcm_rsp_valid = 1'b0;
    chk("collect_count", 32'(wi), 32'(n));
  endtask

  function automatic bit ref_mis(int a, int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(int a, int sz, bit us);
    int unsigned v;
    if (sz == 0) begin
      v = int'(shadow[a]);
      if (!us && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = int'(shadow[a]) + int'(shadow[a+1]) * 256;
      if (!us && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = int'(shadow[a]) + int'(shadow[a+1]) * 256 + int'(shadow[a+2]) * 65536
        + int'(shadow[a+3]) * 16777216;
    end
    return v;
  endfunction

  // One negedge observation step of the random phase: DTCM memory, reference model, scoreboard.
  task automatic monitor();
    if (dtcm_cmd_valid && dtcm_cmd_ready) begin
      if (!dtcm_cmd_read) begin
        for (int b = 0; b < 4; b++)
          if (dtcm_cmd_wmask[b]) dmem[dtcm_cmd_addr[7:2]][8*b +: 8] = dtcm_cmd_wdata[8*b +: 8];
        rsp_q.push_back($urandom);
      end else begin
        rsp_q.push_back(dmem[dtcm_cmd_addr[7:2]]);
      end
    end
    if (agu_cmd_valid && agu_cmd_ready) begin
      int  a  = int'(agu_cmd_addr);
      int  sz = int'(agu_cmd_size);
      bit  m  = ref_mis(a, sz);
      wb_t e;
      chk1("rnd dtcm_valid_on_accept", dtcm_cmd_valid, !m);
      e.tag = agu_cmd_itag; e.err = m; e.wd = 32'h0;
      if (!m) begin
        if (agu_cmd_read) e.wd = ref_load(a, sz, agu_cmd_usign);
        else for (int k = 0; k < (1 << sz); k++) shadow[a+k] = 8'(agu_cmd_wdata >> (8*k));
      end
      wb_q.push_back(e);
    end
    if (dtcm_rsp_valid && dtcm_rsp_ready) void'(rsp_q.pop_front());
    if (lsu_o_valid && lsu_o_ready) begin
      wb_t e;
      if (wb_q.size() == 0) begin
        chk1("rnd unexpected_wb", lsu_o_valid, 1'b0);
      end else begin
        e = wb_q.pop_front();
        chk("rnd tag", 32'(lsu_o_wbck_itag), 32'(e.tag));
        chk("rnd wdat", lsu_o_wbck_wdat, e.wd);
        chk1("rnd err", lsu_o_wbck_err, e.err);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0003, 32'h0,        2'd0, 1'b0, 4'd1,  32'h80FF_FF00, 1'b1, 16'h0000, 4'h0, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 16'h0006, 32'h0000_1234, 2'd1, 1'b0, 4'd2,  32'hDEAD_BEEF, 1'b1, 16'h0004, 4'hC, 32'h1234_1234, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 16'h0002, 32'h0,        2'd2, 1'b0, 4'd5,  32'h0,         1'b0, 16'h0000, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[3]  = '{1'b1, 16'h0001, 32'h0,        2'd0, 1'b1, 4'd3,  32'h0000_8000, 1'b1, 16'h0000, 4'h0, 32'h0,        32'h0000_0080, 1'b0};
    vecs[4]  = '{1'b1, 16'h0002, 32'h0,        2'd1, 1'b0, 4'd4,  32'h8001_0000, 1'b1, 16'h0000, 4'h0, 32'h0,        32'hFFFF_8001, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 32'h0,        2'd1, 1'b1, 4'd6,  32'h1234_F00D, 1'b1, 16'h0000, 4'h0, 32'h0,        32'h0000_F00D, 1'b0};
    vecs[6]  = '{1'b1, 16'h0104, 32'h0,        2'd2, 1'b0, 4'd7,  32'hCAFE_BABE, 1'b1, 16'h0104, 4'h0, 32'h0,        32'hCAFE_BABE, 1'b0};
    vecs[7]  = '{1'b0, 16'h0011, 32'hFFFF_FFA5, 2'd0, 1'b0, 4'd8,  32'h0,         1'b1, 16'h0010, 4'h2, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 16'h0020, 32'h1122_3344, 2'd2, 1'b0, 4'd9,  32'h0,         1'b1, 16'h0020, 4'hF, 32'h1122_3344, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 32'h0,        2'd3, 1'b0, 4'd10, 32'h0,         1'b0, 16'h0000, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 16'h0001, 32'h0000_5678, 2'd1, 1'b0, 4'd11, 32'h0,         1'b0, 16'h0000, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 16'h0000, 32'h0,        2'd0, 1'b0, 4'd12, 32'h0000_007F, 1'b1, 16'h0000, 4'h0, 32'h0,        32'h0000_007F, 1'b0};

    rst = 1'b1;
    set_cmd(1'b0, 1'b0, 16'h0, 32'h0, 2'd0, 1'b0, 4'd0);
    dtcm_cmd_ready = 1'b1; dtcm_rsp_valid = 1'b0; dtcm_rsp_rdata = 32'h0; lsu_o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst lsu_o_valid", lsu_o_valid, 1'b0);
    chk("rst wdat", lsu_o_wbck_wdat, 32'h0);
    chk("rst itag", 32'(lsu_o_wbck_itag), 32'h0);
    chk1("rst err", lsu_o_wbck_err, 1'b0);
    chk1("rst dtcm_rsp_ready", dtcm_rsp_ready, 1'b0);
    chk1("rst agu_ready", agu_cmd_ready, 1'b1);

    // Table-driven single transactions with T+2 writeback latency
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      set_cmd(1'b1, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].size, vecs[i].us, vecs[i].tag);
      dtcm_rsp_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("v%0d agu_ready", i), agu_cmd_ready, 1'b1);
      chk1($sformatf("v%0d dtcm_valid", i), dtcm_cmd_valid, vecs[i].xv);
      if (vecs[i].xv) begin
        chk($sformatf("v%0d dtcm_addr", i), 32'(dtcm_cmd_addr), 32'(vecs[i].xaddr));
        chk($sformatf("v%0d wmask", i), 32'(dtcm_cmd_wmask), 32'(vecs[i].xmask));
        chk1($sformatf("v%0d dtcm_read", i), dtcm_cmd_read, vecs[i].rd);
        if (!vecs[i].rd) chk($sformatf("v%0d dtcm_wdata", i), dtcm_cmd_wdata, vecs[i].xwd);
      end
      @(posedge clk); #1;
      agu_cmd_valid  = 1'b0;
      dtcm_rsp_valid = vecs[i].xv;
      dtcm_rsp_rdata = vecs[i].rdata;
      @(negedge clk);
      chk1($sformatf("v%0d valid_T1", i), lsu_o_valid, 1'b0);
      chk1($sformatf("v%0d rsp_ready", i), dtcm_rsp_ready, vecs[i].xv);
      @(posedge clk); #1;
      dtcm_rsp_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("v%0d valid_T2", i), lsu_o_valid, 1'b1);
      chk($sformatf("v%0d wdat", i), lsu_o_wbck_wdat, vecs[i].xwb);
      chk($sformatf("v%0d itag", i), 32'(lsu_o_wbck_itag), 32'(vecs[i].tag));
      chk1($sformatf("v%0d err", i), lsu_o_wbck_err, vecs[i].xerr);
    end

    // Fill to depth with responses withheld, then release in order
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_cmd(1'b1, 1'b1, 16'(4*i), 32'h0, 2'd2, 1'b0, 4'(i));
      @(negedge clk);
      chk1($sformatf("fill accept%0d", i), agu_cmd_ready, 1'b1);
    end
    @(posedge clk); #1;
    set_cmd(1'b1, 1'b1, 16'h0040, 32'h0, 2'd2, 1'b0, 4'd4);
    @(negedge clk);
    chk1("fill full_ready", agu_cmd_ready, 1'b0);
    chk1("fill full_dtcm_valid", dtcm_cmd_valid, 1'b0);
    @(posedge clk); #1;
    agu_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back(32'hA000 + 32'(i));
      wb_q.push_back('{tag: 4'(i), wd: 32'hA000 + 32'(i), err: 1'b0});
    end
    collect(4);

    // Interleave good load, misaligned load, unsigned byte load
    @(posedge clk); #1;
    set_cmd(1'b1, 1'b1, 16'h0008, 32'h0, 2'd2, 1'b0, 4'd1);
    @(negedge clk); chk1("ilv acc0", agu_cmd_ready, 1'b1);
    @(posedge clk); #1;
    set_cmd(1'b1, 1'b1, 16'h0003, 32'h0, 2'd1, 1'b0, 4'd2);
    @(negedge clk); chk1("ilv acc1", agu_cmd_ready, 1'b1);
    @(posedge clk); #1;
    set_cmd(1'b1, 1'b1, 16'h0001, 32'h0, 2'd0, 1'b1, 4'd3);
    @(negedge clk); chk1("ilv acc2", agu_cmd_ready, 1'b1);
    @(posedge clk); #1;
    agu_cmd_valid = 1'b0;
    rsp_q.push_back(32'h1234_5678);
    rsp_q.push_back(32'h0000_8000);
    wb_q.push_back('{tag: 4'd1, wd: 32'h1234_5678, err: 1'b0});
    wb_q.push_back('{tag: 4'd2, wd: 32'h0,         err: 1'b1});
    wb_q.push_back('{tag: 4'd3, wd: 32'h0000_0080, err: 1'b0});
    collect(3);

    // Reset with three outstanding and a pending writeback
    lsu_o_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_cmd(1'b1, 1'b1, 16'(4*i), 32'h0, 2'd2, 1'b0, 4'(i + 5));
      @(negedge clk);
    end
    @(posedge clk); #1;
    agu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk); chk1("rstop rsp_ready", dtcm_rsp_ready, 1'b1);
    @(posedge clk); #1;
    dtcm_rsp_valid = 1'b0;
    @(negedge clk); chk1("rstop valid_before", lsu_o_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    dtcm_cmd_ready = 1'b0;
    @(negedge clk);
    chk1("rstop lsu_o_valid", lsu_o_valid, 1'b0);
    chk("rstop wdat", lsu_o_wbck_wdat, 32'h0);
    chk("rstop itag", 32'(lsu_o_wbck_itag), 32'h0);
    chk1("rstop rsp_ready0", dtcm_rsp_ready, 1'b0);
    chk1("rstop agu_ready_dtcm0", agu_cmd_ready, 1'b0);
    #1 dtcm_cmd_ready = 1'b1;
    #1 chk1("rstop agu_ready_dtcm1", agu_cmd_ready, 1'b1);
    lsu_o_ready = 1'b1;
    // an emptied FIFO takes exactly DEPTH new commands
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_cmd(1'b1, 1'b1, 16'(4*i), 32'h0, 2'd2, 1'b0, 4'(i));
      @(negedge clk);
      chk1($sformatf("rstop refill%0d", i), agu_cmd_ready, i < 4);
    end
    @(posedge clk); #1;
    agu_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back(32'hB000 + 32'(i));
      wb_q.push_back('{tag: 4'(i), wd: 32'hB000 + 32'(i), err: 1'b0});
    end
    collect(4);

    // Randomized traffic against a byte-level reference memory
    rsp_q.delete();
    wb_q.delete();
    for (int w = 0; w < 64; w++) begin
      dmem[w] = $urandom;
      for (int b = 0; b < 4; b++) shadow[4*w + b] = dmem[w][8*b +: 8];
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r = $urandom_range(0, 9);
      int sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      int a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && sz != 3) a = a & ~((1 << sz) - 1);
      set_cmd($urandom_range(0, 2) != 0, 1'($urandom), 16'(a), $urandom, 2'(sz), 1'($urandom), 4'($urandom));
      dtcm_cmd_ready = ($urandom_range(0, 3) != 0);
      dtcm_rsp_valid = (rsp_q.size() > 0) && ($urandom_range(0, 3) != 0);
      dtcm_rsp_rdata = (rsp_q.size() > 0) ? rsp_q[0] : $urandom;
      lsu_o_ready    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
    end
    agu_cmd_valid = 1'b0; dtcm_cmd_ready = 1'b1; lsu_o_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && (wb_q.size() > 0 || lsu_o_valid); cyc++) begin
      dtcm_rsp_valid = (rsp_q.size() > 0);
      dtcm_rsp_rdata = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
    end
    chk("rnd drain_left", 32'(wb_q.size()), 32'h0);
    begin
      int mism = 0;
      for (int w = 0; w < 64; w++)
        if (dmem[w] !== {shadow[4*w+3], shadow[4*w+2], shadow[4*w+1], shadow[4*w]}) mism++;
      chk("rnd mem_image", 32'(mism), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
